cla_chunk_sequencer: RTL
========================

# cla_chunk_sequencer

Multi-cycle wide adder/subtractor that reuses a single `cla_adder` of width N across CHUNKS successive cycles. It produces a W = N*CHUNKS bit result while instantiating only one N-bit carry-lookahead slice. The block owns the operand latches, the inter-chunk carry register, the chunk index and a start/busy/done handshake. It sits between a requesting control unit and the shared `cla_adder` datapath, and is used where area matters more than single-cycle latency.

## Interface

- `N`, default 8: chunk width and the width of the internal `cla_adder` instance (`cla_adder #(.N(N))`).
- `CHUNKS`, default 4: number of chunks, at least 1. W = N*CHUNKS.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: request. Sampled on the rising edge. Accepted only in IDLE or DONE.
- `a` input, W bits: operand A. Latched when start is accepted.
- `b` input, W bits: operand B. Latched when start is accepted.
- `cin` input, 1 bit: carry-in for add. Latched when start is accepted. Ignored when `sub`=1.
- `sub` input, 1 bit: 1 selects A−B. B is latched inverted and the initial carry is forced to 1.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: one-cycle pulse, high exactly while in DONE.
- `sum` output, W bits: registered result.
- `cout` output, 1 bit: carry out of bit W−1. For subtraction, 1 means no borrow.
- `overflow` output, 1 bit: signed two's-complement overflow of the operation.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch a_r=a and b_r = sub ? ~b : b.
  - Set carry_r = sub ? 1 : cin, idx=0.
  - Go to RUN.
- RUN, each cycle:
  - The adder sees a_r[idx*N +: N], b_r[idx*N +: N] and carry_r.
  - On the edge, write the adder sum into work_r[idx*N +: N], set carry_r to the adder's cout, and increment idx.
  - When idx==CHUNKS−1 on that edge, go to DONE.
  - On the same edge, load sum with the completed work value, including the chunk being written.
  - On the same edge, load cout with the final adder cout.
  - On the same edge, load overflow = (a_r[W−1]==b_r[W−1]) && (final sum[W−1]!=a_r[W−1]).
- DONE:
  - done=1 for exactly one cycle.
  - start=1 is accepted exactly as in IDLE (back-to-back) and goes to RUN. Otherwise go to IDLE.
- `start` in RUN is ignored. It has no effect on operands, idx or the outputs.
- `sum`, `cout` and `overflow` hold their last loaded values until the next entry into DONE. Intermediate chunks are never visible on the outputs.
- Arithmetic is modulo 2^W. No saturation.
- idx width is ceil(log2(CHUNKS)), minimum 1. It never exceeds CHUNKS−1.
- With CHUNKS=1, RUN lasts one cycle.

## Timing

- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, overflow 0. Internal idx, carry_r, a_r, b_r and work_r are also 0.
- Reset asserted mid-RUN or mid-DONE:
  - Takes effect immediately, asynchronously.
  - The operation is abandoned and no done pulse is issued.
  - Outputs return to their reset values.
- Latency, with the start accept edge as E0:
  - busy is high after E0 through E_CHUNKS.
  - done is high in the cycle after E_CHUNKS, so the result is available CHUNKS+1 edges after start.
  - Throughput is one operation per CHUNKS+1 cycles when start is held high.
- busy and done are never high together.

## Test plan

Default parameters apply throughout: N=8, CHUNKS=4, W=32.

- Reset → busy=0, done=0, sum=0, cout=0, overflow=0. Assert reset for 2 cycles, release, then check that outputs stay 0 with start=0.
- Plain add with inter-chunk carry: a=0x000000FF, b=0x00000001, cin=0, sub=0 → sum=0x00000100, cout=0, overflow=0. busy is high for 4 cycles and done pulses once, 5 edges after E0.
- Full ripple: a=0xFFFFFFFF, b=0x00000001 → sum=0x00000000, cout=1, overflow=0. Also a=0xFFFFFFFF, b=0, cin=1 → same result.
- Signed overflow: a=0x7FFFFFFF, b=1 → sum=0x80000000, cout=0, overflow=1. Also a=0x80000000, b=0x80000000 → sum=0, cout=1, overflow=1.
- Subtract, with cin ignored: a=5, b=7, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0, overflow=0. Also a=7, b=5, sub=1 → sum=2, cout=1. Also a=0x80000000, b=1, sub=1 → overflow=1.
- Handshake corner cases, each checked separately:
  - start pulsed during RUN with new operands → ignored, and the original result is delivered.
  - reset at E2 → no done, and outputs are 0.
  - start held high → a second operation begins at the DONE edge, its done follows 5 edges later, and the previous result is held until then.

Source files
------------

// File: rtl/cla_chunk_sequencer.sv
// cla_chunk_sequencer: W-bit add/subtract that runs one N-bit carry-lookahead slice over CHUNKS cycles.
module cla_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   logic [N-1:0] g, p, c;
   logic [N:0]   ci;
   logic         pp;
   assign g = a & b;
   assign p = a ^ b;
   // Each carry is built directly from generate/propagate terms, with no carry-to-carry chain.
   always_comb begin
      c = '0;
      pp = 1'b1;
      for (int i = 0; i < N; i++) begin
         pp = p[i];
         c[i] = g[i];
         for (int j = i - 1; j >= 0; j--) begin
            c[i] = c[i] | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i] = c[i] | (pp & cin);
      end
   end
   assign ci   = {c, cin};
   assign sum  = p ^ ci[N-1:0];
   assign cout = ci[N];
endmodule

module cla_chunk_sequencer #(
   parameter int N      = 8,
   parameter int CHUNKS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [N*CHUNKS-1:0] a,
   input  logic [N*CHUNKS-1:0] b,
   input  logic                cin,
   input  logic                sub,
   output logic                busy,
   output logic                done,
   output logic [N*CHUNKS-1:0] sum,
   output logic                cout,
   output logic                overflow
);
   localparam int W  = N * CHUNKS;
   localparam int IW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t        state, state_next;
   logic [W-1:0]  a_r, b_r, work_r, work_next;
   logic [IW-1:0] idx;
   logic          carry_r, accept, last, chunk_cout;
   logic [N-1:0]  chunk_sum;
   assign accept = start && (state != RUN);
   assign last   = (32'(idx) == CHUNKS - 1);
   cla_adder #(.N(N)) u_add (
      .a    (a_r[idx*N +: N]),
      .b    (b_r[idx*N +: N]),
      .cin  (carry_r),
      .sum  (chunk_sum),
      .cout (chunk_cout)
   );
   // Merges the chunk being written so the final edge can load the complete result.
   always_comb begin
      work_next = work_r;
      work_next[idx*N +: N] = chunk_sum;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end
   always_comb begin
      state_next = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
   end
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r      <= '0;
         b_r      <= '0;
         work_r   <= '0;
         carry_r  <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_r     <= a;
         b_r     <= sub ? ~b : b;
         carry_r <= sub | cin;
         idx     <= '0;
      end else if (state == RUN) begin
         work_r  <= work_next;
         carry_r <= chunk_cout;
         idx     <= last ? '0 : idx + 1'b1;
         if (last) begin
            sum      <= work_next;
            cout     <= chunk_cout;
            overflow <= (a_r[W-1] == b_r[W-1]) && (work_next[W-1] != a_r[W-1]);
         end
      end
   end
endmodule
